calc_op_sequencer: RTL
======================

# calc_op_sequencer

Parametrised, fully registered opcode sequencer for the calculator datapath. It collects operand A, an operator key, and operand B, then executes the operation: ADD/SUB in one cycle, MULT as an iterative multi-cycle multiply. It holds the result for the display and supports chaining a result into the next operation. It sits between the keypad strobe logic and the display mux, and supersedes the fixed 3-bit opcode next-state logic with a generic-width, stateful block.

## Interface
- WIDTH, 8, operand width in bits (signed two's complement); result is 2*WIDTH.
- CHAIN_EN, 1, when 1 an operator key in DONE chains the result into A; when 0 operator keys in DONE are ignored.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  operand from entry register, sampled on enter.
- enter  in  1  single-cycle strobe (debounced/edge-detected upstream).
- op_add, op_sub, op_mult  in  1 each  single-cycle operator strobes.
- op_clear  in  1  single-cycle synchronous clear strobe.
- state  out  3  current state code (display mux select).
- opcode  out  2  latched operator.
- result  out  2*WIDTH  signed result register.
- result_valid  out  1  high while in DONE.
- busy  out  1  high while in EXEC.
- ovf  out  1  sticky: chained result not representable in WIDTH bits.

## Operation
- States: S_A=0 (await A), S_OP=1 (await operator), S_B=2 (await B), S_EXEC=3, S_DONE=4; codes 5–7 are illegal and go to S_A next cycle.
- S_A: enter → capture A=data_in, go to S_OP.
- S_OP: operator strobe → latch opcode, go to S_B. Enter is ignored.
- S_B: enter → capture B=data_in, go to S_EXEC. Operator strobe in S_B replaces the opcode and the state stays S_B.
- S_EXEC: ADD: result = sext(A)+sext(B). SUB: result = sext(A)−sext(B). Both complete in one cycle. MULT: signed product computed over WIDTH+1 cycles. On completion go to S_DONE. All keys except op_clear are ignored.
- S_DONE: enter → go to S_A, keeping result displayed. With CHAIN_EN=1, an operator strobe sets A = result[WIDTH-1:0], latches the opcode, and goes to S_B. It also sets ovf if result[2*WIDTH-1:WIDTH-1] is not all-equal.
- Operator priority when several strobe in the same cycle: ADD > SUB > MULT.
- op_clear has top priority in every state, including mid-EXEC. Next cycle: state S_A, A=B=0, result=0, opcode=ADD, ovf=0, and any multiply is aborted.
- enter together with an operator strobe: the key relevant to the current state wins and the other is dropped.
- Opcode codes: ADD=0, SUB=1, MULT=2; code 3 never latched.

## Timing
- Reset values: state=S_A, opcode=0, result=0, result_valid=0, busy=0, ovf=0, A=B=0.
- All outputs are registered, with no combinational input-to-output path.
- A strobe at edge n changes state at edge n+1.
- ADD/SUB: busy high exactly 1 cycle, result_valid rises the following cycle.
- MULT: busy high exactly WIDTH+1 cycles.
  - Cycle 0 loads magnitudes and the sign.
  - Cycles 1..WIDTH each do one shift-add.
  - The final cycle applies the conditional negate and writes result.
- result is updated only on the EXEC-completion edge or by clear/reset. It is stable throughout S_DONE, S_A, S_OP and S_B.
- An asynchronous reset mid-EXEC takes effect immediately, with no result write.

## Structure
- Package calc_seq_pkg: state code localparams, opcode localparams, and a result-fits-WIDTH helper function.
- One sub-module, calc_seq_mult: iterative signed multiplier.
  - Ports: clk, rst_n, start, abort, a, b, done, product.
  - Parametrised by WIDTH; done pulses on the final cycle.
- Top: state register, operand/opcode registers, ADD/SUB path, priority and chain logic.

## Test plan
- WIDTH=8: 5 enter, op_add, 3 enter → busy for 1 cycle, then result=16'h0008, result_valid=1, state=4.
- 3 enter, op_sub, 5 enter → result=16'hFFFE (−2).
- −4 (8'hFC) enter, op_mult, 7 enter → busy exactly 9 cycles, result=16'hFFE4 (−28); 8'h80×8'h80 → 16'h4000.
- Chain: 100 op_mult 2 enter → 200 (16'h00C8). Then op_add → A=8'hC8, ovf=1. Then 6 enter → result=16'hFFCE.
- op_add and op_mult in the same cycle in S_OP → opcode=0. op_clear on the 4th EXEC cycle of a multiply → next cycle state=0, result=0, busy=0.
- rst_n low mid-MULT → all outputs reset immediately; after release, a fresh 2×3 sequence gives result=6.

Source files
------------

// File: rtl/calc_seq_pkg.sv
// Shared state codes, opcode codes and result-range helper for the calculator sequencer.
// Pure definitions: no latency, no backpressure.
package calc_seq_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;

    // True when the low 2*w bits of val are the sign extension of its low w bits.
    function automatic logic fits_width(input logic [63:0] val, input int w);
        logic [63:0] sx;
        logic [63:0] mask;
        sx   = $signed(val << (64 - w)) >>> (64 - w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return ((sx ^ val) & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/calc_seq_mult.sv
// Iterative signed multiplier: load on cycle 0, one shift-add per cycle for WIDTH cycles.
// done pulses on cycle WIDTH with the signed product; start is ignored while running, abort wins.
module calc_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 active_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    always_comb begin
        // Magnitude of the most negative value still fits unsigned in WIDTH bits.
        mag_a   = a[WIDTH-1] ? -a : a;
        mag_b   = b[WIDTH-1] ? -b : b;
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = active_q && (cnt_q == CW'(WIDTH));
        product = neg_q ? -acc_sum : acc_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (abort) begin
            active_q <= 1'b0;
        end else if (start && !active_q) begin
            active_q <= 1'b1;
            cnt_q    <= CW'(1);
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
        end else if (active_q) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator opcode sequencer: A, operator, B, then ADD/SUB in 1 cycle or MULT in WIDTH+1 cycles.
// All outputs registered; strobe-driven, no backpressure; op_clear overrides everything.
module calc_op_sequencer
    import calc_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 enter,
    input  logic                 op_add,
    input  logic                 op_sub,
    input  logic                 op_mult,
    input  logic                 op_clear,
    output logic [2:0]           state,
    output logic [1:0]           opcode,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 ovf
);

    localparam int RW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         opcode_q, opcode_d;
    logic [RW-1:0]      result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, busy_q;

    logic               any_op;
    logic [1:0]         op_sel;
    logic [RW-1:0]      a_ext, b_ext;
    logic               mult_start;
    logic               mult_done;
    logic [RW-1:0]      mult_product;

    assign any_op     = op_add | op_sub | op_mult;
    assign op_sel     = op_add ? OP_ADD : (op_sub ? OP_SUB : OP_MULT);
    assign a_ext      = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext      = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign mult_start = (state_q == S_EXEC) && (opcode_q == OP_MULT);

    calc_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .abort   (op_clear),
        .a       (a_q),
        .b       (b_q),
        .done    (mult_done),
        .product (mult_product)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opcode_d = opcode_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (op_clear) begin
            state_d  = S_A;
            a_d      = '0;
            b_d      = '0;
            opcode_d = OP_ADD;
            result_d = '0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (enter) begin
                        a_d     = data_in;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (any_op) begin
                        opcode_d = op_sel;
                        state_d  = S_B;
                    end
                end
                // enter completes the entry; a lone operator just re-selects the opcode
                S_B: begin
                    if (enter) begin
                        b_d     = data_in;
                        state_d = S_EXEC;
                    end else if (any_op) begin
                        opcode_d = op_sel;
                    end
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_ADD: begin
                            result_d = a_ext + b_ext;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            result_d = a_ext - b_ext;
                            state_d  = S_DONE;
                        end
                        OP_MULT: begin
                            if (mult_done) begin
                                result_d = mult_product;
                                state_d  = S_DONE;
                            end
                        end
                        default: state_d = S_A;
                    endcase
                end
                S_DONE: begin
                    if (enter) begin
                        state_d = S_A;
                    end else if (CHAIN_EN && any_op) begin
                        a_d      = result_q[WIDTH-1:0];
                        opcode_d = op_sel;
                        state_d  = S_B;
                        if (!fits_width(64'(result_q), WIDTH)) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= OP_ADD;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= (state_d == S_DONE);
            busy_q   <= (state_d == S_EXEC);
        end
    end

    assign state        = state_q;
    assign opcode       = opcode_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign ovf          = ovf_q;

endmodule
